box_mover: RTL and testbench

- Consumes the frame counter's move strobe and animates one square block along a fixed row of the 160x120 VGA frame buffer.
- On each strobe it erases the block, steps it one pixel horizontally (bouncing at the screen edges), then redraws it.
- Drives the VGA adapter's pixel-write port: x, y, colour, plot.
- On a player stop request it freezes the block in place and reports its final column to the game controller.

---
 rtl/box_mover_if.sv | 12 +
 rtl/box_mover.sv | 140 ++++++++++++++
 tb/tb_box_mover.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/box_mover_if.sv
// Pixel-write port toward the VGA adapter: one pixel per cycle when plot is high.
// Latency: purely combinational bundle, no storage.
// Backpressure: none; the adapter must accept a pixel on every cycle plot is high.
interface box_mover_if;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] colour_out;
   logic       plot;

   modport master (output x_out, output y_out, output colour_out, output plot);
   modport slave  (input  x_out, input  y_out, input  colour_out, input  plot);
endinterface

// File: rtl/box_mover.sv
// Animates one BOX_SIZE square along a row: erase, step one column, redraw (BOX_MOVER_WRAP_EN: wrap instead of bounce).
// Latency: move edge seen in WAIT -> first erase pixel next cycle; back in WAIT 34 cycles after that edge.
// Backpressure: none; move edges outside WAIT are dropped, a stop is held pending until the block is fully redrawn.
module box_mover #(
   parameter int         BOX_SIZE = 4,
   parameter int         SCREEN_W = 160,
   parameter logic [2:0] COLOUR   = 3'b111
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        move_tick,
   input  logic        stop,
   input  logic        restart,
   input  logic [6:0]  row_y,
   box_mover_if.master pix,
   output logic        busy,
   output logic        locked,
   output logic [7:0]  box_x
);
   // Rightmost legal left column of the block.
   localparam logic [7:0] X_MAX = 8'(SCREEN_W - BOX_SIZE);

   typedef enum logic [2:0] {
      S_INIT, S_DRAW, S_WAIT, S_ERASE, S_UPDATE, S_STOPPED
   } state_t;

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;          // pixel index inside the block: dx = cnt[1:0], dy = cnt[3:2]
   logic [7:0] x_q, x_nxt;
   logic       dir_left, dir_left_nxt;
   logic       stop_pend, stop_pend_nxt;
   logic       locked_q, locked_nxt;
   logic       tick_d;
   logic       tick_edge;

   // The frame counter strobe is a level; only its rising edge requests a move.
   assign tick_edge = move_tick & ~tick_d;
   assign box_x     = x_q;
   assign locked    = locked_q;

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_INIT;
         cnt       <= 4'd0;
         x_q       <= 8'd0;
         dir_left  <= 1'b0;
         stop_pend <= 1'b0;
         locked_q  <= 1'b0;
         tick_d    <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         x_q       <= x_nxt;
         dir_left  <= dir_left_nxt;
         stop_pend <= stop_pend_nxt;
         locked_q  <= locked_nxt;
         tick_d    <= move_tick;
      end
   end

   // Next-state decode, pixel port drive and block stepping.
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      x_nxt          = x_q;
      dir_left_nxt   = dir_left;
      stop_pend_nxt  = stop_pend;
      locked_nxt     = 1'b0;
      busy           = 1'b0;
      pix.plot       = 1'b0;
      pix.x_out      = 8'd0;
      pix.y_out      = 7'd0;
      pix.colour_out = 3'b000;

      case (state)
         S_INIT: state_nxt = S_DRAW;

         // Erase and draw walk the same 16 pixels; only the colour and exit differ.
         S_DRAW, S_ERASE: begin
            busy           = 1'b1;
            pix.plot       = 1'b1;
            pix.x_out      = x_q + {6'd0, cnt[1:0]};
            pix.y_out      = row_y + {5'd0, cnt[3:2]};
            pix.colour_out = (state == S_DRAW) ? COLOUR : 3'b000;
            cnt_nxt        = cnt + 4'd1;
            if (stop) stop_pend_nxt = 1'b1;
            if (cnt == 4'd15) state_nxt = (state == S_DRAW) ? S_WAIT : S_UPDATE;
         end

         S_UPDATE: begin
            busy      = 1'b1;
            state_nxt = S_DRAW;
            if (stop) stop_pend_nxt = 1'b1;
`ifdef BOX_MOVER_WRAP_EN
            dir_left_nxt = 1'b0;
            x_nxt        = (x_q == X_MAX) ? 8'd0 : x_q + 8'd1;
`else
            if (!dir_left) begin
               if (x_q == X_MAX) begin
                  dir_left_nxt = 1'b1;
                  x_nxt        = X_MAX - 8'd1;
               end else begin
                  x_nxt = x_q + 8'd1;
               end
            end else begin
               if (x_q == 8'd0) begin
                  dir_left_nxt = 1'b0;
                  x_nxt        = 8'd1;
               end else begin
                  x_nxt = x_q - 8'd1;
               end
            end
`endif
         end

         // Stop wins over a simultaneous move edge.
         S_WAIT: begin
            if (stop || stop_pend) begin
               state_nxt     = S_STOPPED;
               stop_pend_nxt = 1'b0;
               locked_nxt    = 1'b1;
            end else if (tick_edge) begin
               state_nxt = S_ERASE;
            end
         end

         // Block stays on screen; only restart leaves, starting a fresh block at column 0.
         S_STOPPED: begin
            if (restart) begin
               x_nxt        = 8'd0;
               dir_left_nxt = 1'b0;
               state_nxt    = S_DRAW;
            end
         end

         default: state_nxt = S_INIT;
      endcase
   end
endmodule

// File: tb/tb_box_mover.sv
// Bench for box_mover: randomized moves checked against a position-vs-move-count model.
// Latency: checks every cycle of each erase/update/draw sequence at the falling edge.
// Backpressure: not applicable; the pixel port is always accepted.
`timescale 1ns/1ps
module tb_box_mover;
   logic       clk = 1'b0;
   logic       reset, move_tick, stop, restart;
   logic [6:0] row_y;
   logic       busy, locked;
   logic [7:0] box_x;

   box_mover_if pix ();

   box_mover dut (
      .clk       (clk),
      .reset     (reset),
      .move_tick (move_tick),
      .stop      (stop),
      .restart   (restart),
      .row_y     (row_y),
      .pix       (pix),
      .busy      (busy),
      .locked    (locked),
      .box_x     (box_x)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int m_n   = 0;   // moves since the current block was started

   // Column after n moves: triangle wave 0..156..0 (period 312), or sawtooth 0..156 when wrapping.
   function automatic int exp_x(input int n);
`ifdef BOX_MOVER_WRAP_EN
      return n % 157;
`else
      int p = n % 312;
      return (p <= 156) ? p : 312 - p;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_chk(input string tag);
      @(negedge clk);
      chk(tag, {pix.plot, busy, pix.x_out, pix.y_out, pix.colour_out}, 32'd0);
   endtask

   // Checks the 16 pixels of a fresh draw at column x0, then the WAIT cycle.
   task automatic draw16(input int x0, input string tag);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         chk(tag, {pix.plot, busy, pix.x_out, pix.y_out, pix.colour_out},
             {2'b11, 8'(x0 + k % 4), 7'(row_y + k / 4), 3'b111});
         restart = 1'b0;
      end
      @(negedge clk);
      chk({tag, "_wait"}, {pix.plot, busy, box_x}, {2'b00, 8'(x0)});
   endtask

   // One full move; called with move_tick just raised in WAIT.
   // drop_at/rise_at toggle move_tick mid-sequence, stop_at raises stop for two cycles (-1 = unused).
   task automatic move_seq(input int drop_at, input int rise_at, input int stop_at);
      int ox, nx;
      ox = exp_x(m_n);
      m_n++;
      nx = exp_x(m_n);
      for (int k = 0; k < 33; k++) begin
         @(negedge clk);
         if (k < 16)
            chk("erase_px", {pix.plot, busy, pix.x_out, pix.y_out, pix.colour_out},
                {2'b11, 8'(ox + k % 4), 7'(row_y + k / 4), 3'b000});
         else if (k == 16)
            chk("update", {pix.plot, busy, pix.x_out, pix.y_out, pix.colour_out}, {2'b01, 18'd0});
         else
            chk("draw_px", {pix.plot, busy, pix.x_out, pix.y_out, pix.colour_out},
                {2'b11, 8'(nx + (k - 17) % 4), 7'(row_y + (k - 17) / 4), 3'b111});
         if (k == drop_at) move_tick = 1'b0;
         if (k == rise_at) move_tick = 1'b1;
         if (k == stop_at) stop = 1'b1;
         if (stop_at >= 0 && k == stop_at + 2) stop = 1'b0;
      end
      @(negedge clk);
      chk("move_wait", {pix.plot, busy, locked, box_x}, {3'b000, 8'(nx)});
`ifdef BOX_MOVER_WRAP_EN
      if (m_n == 157) chk("wrap_to_0", box_x, 32'd0);
`else
      if (m_n == 157) chk("bounce_right", box_x, 32'd155);
      if (m_n == 313) chk("bounce_left", box_x, 32'd1);
`endif
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; move_tick = 1'b0; stop = 1'b0; restart = 1'b0; row_y = 7'd20;
      #1;
      chk("reset_outs", {pix.plot, pix.x_out, pix.y_out, pix.colour_out, busy, locked, box_x}, 32'd0);
      #20;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("init_idle", {pix.plot, busy, locked, box_x}, 32'd0);
      m_n = 0;
      draw16(0, "init_draw");

      // First move with move_tick held high for 10 cycles: one move only.
      move_tick = 1'b1;
      move_seq(-1, -1, -1);
      repeat (10) idle_chk("held_level_idle");
      move_tick = 1'b0;
      idle_chk("tick_low_idle");

      // Stop raised during ERASE: sequence completes, then lock.
      move_tick = 1'b1;
      move_seq(-1, -1, 3);
      @(negedge clk);
      chk("locked_pulse", {locked, pix.plot, busy}, 3'b100);
      repeat (3) begin
         @(negedge clk);
         chk("locked_once", {locked, pix.plot, busy}, 3'b000);
      end
      move_tick = 1'b0;
      @(negedge clk);
      move_tick = 1'b1;
      repeat (40) idle_chk("stopped_no_plot");
      chk("stopped_box_x", box_x, 32'(exp_x(m_n)));

      // Restart draws a fresh block at column 0 without erasing the old one.
      move_tick = 1'b0;
      row_y     = 7'($urandom_range(0, 116));
      restart   = 1'b1;
      m_n       = 0;
      draw16(0, "restart_draw");

      // Randomized moves: enough to cross both edges.
      for (int i = 0; i < 320; i++) begin
         int hold, d, r;
         hold = $urandom_range(1, 4);
         d = -1;
         r = -1;
         if ($urandom_range(0, 3) == 0) begin
            d = $urandom_range(0, 20);
            if ($urandom_range(0, 1) == 1) r = d + $urandom_range(1, 10);
         end
         move_tick = 1'b0;
         idle_chk("gap_idle");
         row_y     = 7'($urandom_range(0, 116));
         move_tick = 1'b1;
         move_seq(d, r, -1);
         repeat (hold) idle_chk("post_move_idle");
      end

      // Asynchronous reset in the middle of DRAW.
      move_tick = 1'b0;
      @(negedge clk);
      move_tick = 1'b1;
      repeat (20) @(negedge clk);
      chk("mid_draw_plot", {pix.plot, busy}, 2'b11);
      #2 reset = 1'b1;
      #1;
      chk("async_reset", {pix.plot, pix.x_out, pix.y_out, pix.colour_out, busy, locked, box_x}, 32'd0);
      move_tick = 1'b0;
      m_n = 0;
      repeat (3) @(negedge clk);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("reinit_idle", {pix.plot, busy, box_x}, 32'd0);
      draw16(0, "reinit_draw");
      for (int i = 0; i < 3; i++) begin
         move_tick = 1'b0;
         idle_chk("tail_gap_idle");
         move_tick = 1'b1;
         move_seq(-1, -1, -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
